alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the data width; legal range is 4 to 64.
REQ-002 The module SHALL have parameter MUL_EN, default 1; when 1 the iterative multiply mode is present.
REQ-003 clk  input  1  The only clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  Asynchronous, active-low reset.
REQ-005 in_valid  input  1  Operand/command valid.
REQ-006 in_ready  output  1  Block can accept a command this cycle.
REQ-007 x, y  input  WIDTH each  Operands.
REQ-008 ctrl  input  6  {zx,nx,zy,ny,f,no}, with the standard Hack ALU meaning.
REQ-009 mul  input  1  1 = multiply mode: preprocessed x times y replaces the f stage.
REQ-010 out_valid  output  1  Result valid.
REQ-011 out_ready  input  1  Consumer accepts the result.
REQ-012 out  output  WIDTH  Registered result.
REQ-013 zr, ng, cy  output  1 each  zr: out==0. ng: out[WIDTH-1]. cy: adder carry-out.

Function
REQ-014 A transfer SHALL occur on any edge where in_valid and in_ready are both 1; x, y, ctrl and mul SHALL be captured at that edge.
REQ-015 Preprocessing SHALL be applied to the captured operands: zx zeroes x, then nx inverts x; zy and ny do the same for y.
REQ-016 With mul=0 (or MUL_EN=0), the f stage SHALL be the WIDTH-bit sum (f=1, carry discarded) or the bitwise AND (f=0); no inverts the result.
REQ-017 cy SHALL be the carry out of the WIDTH-bit addition, taken before the no stage, when f=1 and mul=0; otherwise cy SHALL be 0.
REQ-018 The FSM SHALL have three states: IDLE, MUL, HOLD.
REQ-019 Non-multiply commands SHALL go from IDLE or HOLD to HOLD at the transfer edge, with out_valid=1 after that edge (latency 1 cycle).
REQ-020 Multiply commands SHALL go from IDLE or HOLD to MUL at the transfer edge.
REQ-021 MUL SHALL perform one shift-add step per cycle for exactly WIDTH cycles, then enter HOLD; out_valid SHALL rise WIDTH+1 edges after the transfer edge.
REQ-022 The multiply product SHALL be the low WIDTH bits of the preprocessed x times preprocessed y, unsigned; no SHALL then be applied; f SHALL be ignored.
REQ-023 zr and ng SHALL be computed from the final out and registered together with out.
REQ-024 in_ready SHALL be 1 in IDLE, 0 in MUL, and equal to out_ready in HOLD.
REQ-025 In HOLD with out_ready=1 and in_valid=0, the block SHALL return to IDLE and drop out_valid.
REQ-026 In HOLD with out_ready=1 and in_valid=1, the new command SHALL be accepted in the same cycle, giving 1 result per cycle for non-multiply ops.
REQ-027 While out_valid=1 and out_ready=0, out, zr, ng and cy SHALL hold stable.
REQ-028 During MUL, out, zr, ng and cy SHALL keep their previous values and out_valid SHALL be 0.
REQ-029 With MUL_EN=0, the mul input SHALL be ignored and no MUL state logic shall be generated.

Reset
REQ-030 While rst_n=0, regardless of clk: state=IDLE, out=0, zr=0, ng=0, cy=0, out_valid=0, in_ready=1, and the multiply accumulator/counter are cleared.
REQ-031 Reset asserted during MUL SHALL abort the operation; no result from the aborted command is ever presented.

Verification (WIDTH=16)
REQ-032 Reset: release rst_n with no input -> out=0x0000, out_valid=0, in_ready=1, zr=ng=cy=0.
REQ-033 x=0x0003, y=0x0005, ctrl=010011 (x-y), out_ready=1 -> next cycle out=0xFFFE, ng=1, zr=0, cy=1, out_valid=1.
REQ-034 x=0x8000, y=0x8000, ctrl=000010 -> out=0x0000, zr=1, cy=1.
REQ-035 x=0x0007, y=0x0006, ctrl=000000, mul=1 -> in_ready=0 for 16 cycles; out_valid at edge 17 with out=0x002A.
REQ-036 Backpressure: hold out_ready=0 for 3 cycles after a result -> out stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new command accepted that cycle, back-to-back results.
REQ-037 Pull rst_n low 5 cycles into a multiply -> out_valid=0 immediately. After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq -- Hack-style ALU with an optional iterative shift-add multiply.
//
// A command (x, y, ctrl, mul) is captured on any edge where in_valid and
// in_ready are both high. The ALU path returns a result one cycle later. The
// multiply path runs one shift-add step per cycle for WIDTH cycles, then
// spends one more edge registering the product. Results are held in a
// registered output stage until the consumer accepts them.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  command handshake
//   x, y [WIDTH]        operands
//   ctrl [6]            {zx, nx, zy, ny, f, no}
//   mul                 1 = multiply mode (only when MUL_EN != 0)
//   out_valid, out_ready result handshake
//   out [WIDTH]         registered result
//   zr, ng, cy          zero, negative and adder carry-out flags
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t stateQ, stateD;

  logic [WIDTH-1:0] px, py, fRes, aluRes, mulResult;
  logic [WIDTH:0]   sum;
  logic             aluCy, mulCmd, mulDone, take;
  logic             loadAlu, startMul, finishMul;

  // Operand preprocessing and the single-cycle ALU datapath
  always_comb begin
    px = ctrl[5] ? {WIDTH{1'b0}} : x;
    if (ctrl[4]) begin
      px = ~px;
    end else begin
      px = px;
    end
    py = ctrl[3] ? {WIDTH{1'b0}} : y;
    if (ctrl[2]) begin
      py = ~py;
    end else begin
      py = py;
    end
    sum    = {1'b0, px} + {1'b0, py};
    fRes   = ctrl[1] ? sum[WIDTH-1:0] : (px & py);
    aluRes = ctrl[0] ? ~fRes : fRes;
    // carry is taken before the output invert and only for the add
    aluCy  = ctrl[1] & sum[WIDTH];
  end

  // Input handshake depends on state; in HOLD a new command may enter only
  // in the cycle the held result is consumed
  always_comb begin
    in_ready = 1'b0;
    case (stateQ)
      IDLE:    in_ready = 1'b1;
      MUL:     in_ready = 1'b0;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign out_valid = (stateQ == HOLD);
  assign take      = in_valid & in_ready;

  // Next-state logic and datapath load strobes
  always_comb begin
    stateD    = stateQ;
    loadAlu   = 1'b0;
    startMul  = 1'b0;
    finishMul = 1'b0;
    case (stateQ)
      IDLE, HOLD: begin
        if (take) begin
          if (mulCmd) begin
            stateD   = MUL;
            startMul = 1'b1;
          end else begin
            stateD  = HOLD;
            loadAlu = 1'b1;
          end
        end else if ((stateQ == HOLD) && !out_ready) begin
          stateD = HOLD;
        end else begin
          stateD = IDLE;
        end
      end
      MUL: begin
        if (mulDone) begin
          stateD    = HOLD;
          finishMul = 1'b1;
        end else begin
          stateD = MUL;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  generate
    if (MUL_EN != 0) begin : gMul
      logic [WIDTH-1:0] mcandQ, mplierQ, accQ;
      logic [CNT_W-1:0] cntQ;
      logic             noQ;

      assign mulCmd    = mul;
      assign mulDone   = (cntQ == CNT_W'(WIDTH));
      assign mulResult = noQ ? ~accQ : accQ;

      // Shift-add multiplier: multiplicand shifts left, multiplier shifts
      // right, one partial product accumulated per cycle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mcandQ  <= {WIDTH{1'b0}};
          mplierQ <= {WIDTH{1'b0}};
          accQ    <= {WIDTH{1'b0}};
          cntQ    <= {CNT_W{1'b0}};
          noQ     <= 1'b0;
        end else if (startMul) begin
          mcandQ  <= px;
          mplierQ <= py;
          accQ    <= {WIDTH{1'b0}};
          cntQ    <= {CNT_W{1'b0}};
          noQ     <= ctrl[0];
        end else if ((stateQ == MUL) && !mulDone) begin
          accQ    <= accQ + (mplierQ[0] ? mcandQ : {WIDTH{1'b0}});
          mcandQ  <= mcandQ << 1;
          mplierQ <= mplierQ >> 1;
          cntQ    <= cntQ + CNT_W'(1);
        end else begin
          accQ <= accQ;
        end
      end
    end else begin : gNoMul
      assign mulCmd    = 1'b0;
      assign mulDone   = 1'b0;
      assign mulResult = {WIDTH{1'b0}};
    end
  endgenerate

  // Output register: loaded only by a finished command, otherwise held so
  // results stay stable under backpressure and during a multiply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= {WIDTH{1'b0}};
      zr  <= 1'b0;
      ng  <= 1'b0;
      cy  <= 1'b0;
    end else if (loadAlu) begin
      out <= aluRes;
      zr  <= (aluRes == {WIDTH{1'b0}});
      ng  <= aluRes[WIDTH-1];
      cy  <= aluCy;
    end else if (finishMul) begin
      out <= mulResult;
      zr  <= (mulResult == {WIDTH{1'b0}});
      ng  <= mulResult[WIDTH-1];
      cy  <= 1'b0;
    end else begin
      out <= out;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=16, MUL_EN=1). Expected results are pushed to
// a scoreboard queue when a command is issued; a monitor pops and compares
// on every accepted output beat.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, mul, out_valid, out_ready;
  logic         zr, ng, cy;
  logic [W-1:0] x, y, out;
  logic [5:0]   ctrl;

  // expected beat packed as {out, zr, ng, cy}
  typedef logic [W+2:0] exp_t;
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl), .mul(mul), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zr(zr), .ng(ng), .cy(cy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W+2:0] act,
                     input logic [W+2:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every beat accepted by the consumer is compared
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result actual=%h required=none", out);
        end else begin
          e = sb.pop_front();
          if ({out, zr, ng, cy} !== e) begin
            bad++;
            $display("FAIL result actual=%h required=%h", {out, zr, ng, cy}, e);
          end
        end
      end
    end
  end

  // Issue one command; returns one time unit after the transfer edge
  task automatic send(input logic [W-1:0] xv, input logic [W-1:0] yv,
                      input logic [5:0] c, input logic m, input logic doPush,
                      input exp_t e);
    bit ok = 1'b0;
    x = xv; y = yv; ctrl = c; mul = m; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("send_timeout", {{(W+2){1'b0}}, in_ready}, {{(W+2){1'b0}}, 1'b1});
      in_valid = 1'b0;
    end else begin
      if (doPush) sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mul = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; ctrl = 6'b000000;
    #1;
    chk("reset_async", {out, zr, ng, cy, out_valid, in_ready},
        {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_release", {out, zr, ng, cy, out_valid, in_ready},
        {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;

    // x - y : 3 - 5
    out_ready = 1'b1;
    send(16'h0003, 16'h0005, 6'b010011, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    chk("alu_latency1", {{(W+2){1'b0}}, out_valid}, {{(W+2){1'b0}}, 1'b1});
    @(posedge clk); #1;

    // back-to-back ALU commands
    send(16'h8000, 16'h8000, 6'b000010, 1'b0, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1});
    send(16'h1234, 16'h5678, 6'b101010, 1'b0, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b0});
    send(16'h1234, 16'h5678, 6'b001100, 1'b0, 1'b1, {16'h1234, 1'b0, 1'b0, 1'b0});
    send(16'h00F0, 16'h0FF0, 6'b000000, 1'b0, 1'b1, {16'h00F0, 1'b0, 1'b0, 1'b0});
    send(16'h7FFF, 16'h0000, 6'b011111, 1'b0, 1'b1, {16'h8000, 1'b0, 1'b1, 1'b1});

    // multiply 7 * 6 with cycle-exact timing
    send(16'h0007, 16'h0006, 6'b000000, 1'b1, 1'b1, {16'h002A, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk("mul_busy_valid", {{(W+2){1'b0}}, out_valid}, {(W+3){1'b0}});
      if (i < 16) chk("mul_busy_ready", {{(W+2){1'b0}}, in_ready}, {(W+3){1'b0}});
      if (i == 8) chk("mul_out_hold", {out, zr, ng, cy}, {16'h8000, 1'b0, 1'b1, 1'b1});
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("mul_valid_edge17", {{(W+2){1'b0}}, out_valid}, {{(W+2){1'b0}}, 1'b1});
    @(posedge clk); #1;

    // multiply with output invert, with nx, and with f=1 ignored
    send(16'h0003, 16'h0004, 6'b000001, 1'b1, 1'b1, {16'hFFF3, 1'b0, 1'b1, 1'b0});
    send(16'h0001, 16'h0003, 6'b010000, 1'b1, 1'b1, {16'hFFFA, 1'b0, 1'b1, 1'b0});
    send(16'h0100, 16'h0100, 6'b000010, 1'b1, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b0});
    repeat (20) @(posedge clk);
    #1;

    // backpressure: result A held 3 cycles while B waits, then A/B/C stream
    out_ready = 1'b0;
    send(16'h0003, 16'h0005, 6'b000010, 1'b0, 1'b1, {16'h0008, 1'b0, 1'b0, 1'b0});
    x = 16'h00FF; y = 16'h0F0F; ctrl = 6'b000000; mul = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold", {out, zr, ng, cy}, {16'h0008, 1'b0, 1'b0, 1'b0});
      chk("bp_flags", {{(W+1){1'b0}}, out_valid, in_ready}, {{(W+1){1'b0}}, 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    sb.push_back({16'h000F, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    chk("bp_accept_b", {{(W+2){1'b0}}, in_ready}, {{(W+2){1'b0}}, 1'b1});
    @(posedge clk); #1;
    x = 16'h0010; y = 16'h0002; ctrl = 6'b010011;
    sb.push_back({16'h000E, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    chk("bp_accept_c", {{(W+1){1'b0}}, out_valid, in_ready}, {{(W+1){1'b0}}, 1'b1, 1'b1});
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;

    // reset five cycles into a multiply: aborted, no result ever appears
    send(16'h0009, 16'h0009, 6'b000000, 1'b1, 1'b0, '0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_async", {out, zr, ng, cy, out_valid, in_ready},
        {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_after", {out, zr, ng, cy, out_valid, in_ready},
        {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

    chk("scoreboard_drained", (W+3)'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
